// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared constants and FSM state type for the frequency meter.
// Build option FREQ_METER_SYNC_EN (see sync_edge_det) does not affect this file.
package freq_meter_pkg;

    localparam int CNT_W_DEF       = 40;
    localparam int GATE_W_DEF      = 32;
    localparam int GATE_CYCLES_DEF = 50_000_000;

    // Largest value the default-width edge counter can hold before saturating.
    localparam logic [CNT_W_DEF-1:0] SAT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: result bus between the meter and the SPI slave that shifts it out.
// Handshake: o_valid is a 1-cycle strobe meaning o_freq/o_ovf were reloaded on the
// preceding clock edge; there is no ready. The consumer asserts i_hold to freeze
// o_freq/o_ovf for a whole frame; results finishing meanwhile wait in a single-entry
// pending slot (newest wins, o_drop strobes when an unread result is discarded).
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             i_hold;
    logic [CNT_W-1:0] o_freq;
    logic             o_valid;
    logic             o_ovf;
    logic             o_drop;

    modport master (
        input  i_hold,
        output o_freq, o_valid, o_ovf, o_drop
    );

    modport slave (
        output i_hold,
        input  o_freq, o_valid, o_ovf, o_drop
    );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: brings i_sig into the i_clk domain and flags its rising edges.
// FREQ_METER_SYNC_EN defined: 2-FF synchronizer ahead of the delay FF (3-edge latency).
// Undefined: i_sig is already synchronous, only the delay FF is kept (1-edge latency).
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic sig_s;
    logic dly_q;

`ifdef FREQ_METER_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for the asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], i_sig};
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = i_sig;
`endif

    // One-cycle delayed copy used to spot the 0->1 transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) dly_q <= 1'b0;
        else          dly_q <= sig_s;
    end

    assign o_edge = sig_s & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of i_sig over a gate of GATE_CYCLES clocks and
// publishes the count on the result bus, with hold/pending handling for the SPI slave.
// Build option: FREQ_METER_SYNC_EN selects the input synchronizer in sync_edge_det.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int GATE_W      = GATE_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sig,
    input  logic         i_enable,
    freq_meter_if.master bus,
    output state_t       o_dbg_state
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic sig_edge;

    sync_edge_det u_sync_edge_det (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_sig),
        .o_edge  (sig_edge)
    );

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               gate_end;

    logic [CNT_W-1:0]   pend_val_q, pend_val_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               fovf_q, fovf_d;
    logic               valid_q, valid_d;
    logic               drop_q, drop_d;

    // Running count including this cycle's edge; also the capture value at gate end.
    logic               cap_sat;
    logic [CNT_W-1:0]   cap_cnt;
    logic               cap_ovf;

    assign cap_sat = sig_edge && (cnt_q == CNT_MAX);
    assign cap_cnt = cap_sat ? cnt_q : cnt_q + CNT_W'(sig_edge);
    assign cap_ovf = ovf_q | cap_sat;

    // Gate FSM: next state and gate/edge counters; an early enable drop discards the gate.
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        gate_end = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
                if (i_enable) state_d = RUN;
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Back-to-back gates: the next one starts on the following cycle.
                    gate_end = 1'b1;
                    gate_d   = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    cnt_d  = cap_cnt;
                    ovf_d  = cap_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate FSM state and counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Publish/pending decision: a fresh capture always beats an older pending value.
    always_comb begin
        freq_d     = freq_q;
        fovf_d     = fovf_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_ovf_d = pend_ovf_q;
        valid_d    = 1'b0;
        drop_d     = 1'b0;
        if (gate_end) begin
            drop_d = pend_q;
            if (bus.i_hold) begin
                pend_d     = 1'b1;
                pend_val_d = cap_cnt;
                pend_ovf_d = cap_ovf;
            end else begin
                pend_d  = 1'b0;
                freq_d  = cap_cnt;
                fovf_d  = cap_ovf;
                valid_d = 1'b1;
            end
        end else if (pend_q && !bus.i_hold) begin
            pend_d  = 1'b0;
            freq_d  = pend_val_q;
            fovf_d  = pend_ovf_q;
            valid_d = 1'b1;
        end
    end

    // Published result, pending slot and strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            freq_q     <= '0;
            fovf_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            pend_ovf_q <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            freq_q     <= freq_d;
            fovf_q     <= fovf_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_ovf_q <= pend_ovf_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.o_freq   = freq_q;
    assign bus.o_ovf    = fovf_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_drop   = drop_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven rate checks, hand-built hold/drop/enable/reset/boundary
// sequences and a randomized run checked every cycle against a behavioural model.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int GA  = 100;
  localparam int GB  = 40;
  localparam int CWB = 3;
`ifdef FREQ_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam longint MAXA = (longint'(1) << 40) - 1;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic hold_a = 1'b0;
  logic sig_manual = 1'b0;
  logic gen_sig = 1'b0;
  logic sig;
  int   period = 0;
  int   ph = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  assign sig = (period == 0) ? sig_manual : gen_sig;

  freq_meter_if #(.CNT_W(40))  bus_a ();
  freq_meter_if #(.CNT_W(CWB)) bus_b ();
  state_t dbg_a, dbg_b;

  assign bus_a.i_hold = hold_a;
  assign bus_b.i_hold = 1'b0;

  freq_meter #(.CNT_W(40), .GATE_CYCLES(GA), .GATE_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig), .i_enable(en),
    .bus(bus_a), .o_dbg_state(dbg_a)
  );

  freq_meter #(.CNT_W(CWB), .GATE_CYCLES(GB), .GATE_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig), .i_enable(en),
    .bus(bus_b), .o_dbg_state(dbg_b)
  );

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int va_cnt = 0;
  int da_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, want);
  endtask

  // Periodic signal: one rising edge every 'period' clocks.
  initial forever begin
    @(negedge clk);
    if (period > 0) begin
      ph = (ph + 1 >= period) ? 0 : ph + 1;
      gen_sig = (ph < period / 2);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (bus_a.o_valid === 1'b1) va_cnt++;
    if (bus_a.o_drop === 1'b1) da_cnt++;
  end

  // ---------------- behavioural reference model (dut_a) ----------------
  logic [3:0] sh = '0;
  bit     m_run = 0, m_pend = 0, m_po = 0;
  int     m_n = 0;
  longint m_cnt = 0, m_pv = 0;
  longint e_freq = 0;
  bit     e_ovf = 0, e_valid = 0, e_drop = 0;

  task automatic model_step();
    longint cap;
    bit cap_o, gate_done, m_edge;
    cap = 0; cap_o = 0; gate_done = 0;
    if (!rst_n) begin
      sh = '0; m_run = 0; m_n = 0; m_cnt = 0; m_pend = 0; m_pv = 0; m_po = 0;
      e_freq = 0; e_ovf = 0; e_valid = 0; e_drop = 0;
    end else begin
      sh = {sh[2:0], sig};
      m_edge = sh[LAT-1] & ~sh[LAT];
      if (!m_run) begin
        m_run = en;
      end else if (!en) begin
        m_run = 0; m_n = 0; m_cnt = 0;
      end else begin
        m_cnt += longint'(m_edge);
        m_n++;
        if (m_n == GA) begin
          gate_done = 1;
          cap   = (m_cnt > MAXA) ? MAXA : m_cnt;
          cap_o = (m_cnt > MAXA);
          m_n = 0; m_cnt = 0;
        end
      end
      e_valid = 0; e_drop = 0;
      if (gate_done) begin
        if (m_pend) e_drop = 1;
        if (hold_a) begin
          m_pend = 1; m_pv = cap; m_po = cap_o;
        end else begin
          m_pend = 0; e_freq = cap; e_ovf = cap_o; e_valid = 1;
        end
      end else if (m_pend && !hold_a) begin
        e_freq = m_pv; e_ovf = m_po; e_valid = 1; m_pend = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Scoreboard: every cycle, dut_a outputs against the model.
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("mdl_freq",  bus_a.o_freq,  e_freq);
      chk("mdl_ovf",   bus_a.o_ovf,   e_ovf);
      chk("mdl_valid", bus_a.o_valid, e_valid);
      chk("mdl_drop",  bus_a.o_drop,  e_drop);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input bit sel, output int cycles);
    bit ok;
    ok = 0;
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cycles++;
      if ((sel ? bus_b.o_valid : bus_a.o_valid) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk(sel ? "b_valid_timeout" : "a_valid_timeout", ok, 1'b1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit     sel;
    int     period;
    longint exp_freq;
    bit     exp_ovf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int cy, c0, v0, d0;
    tbl[0] = '{0, 10, 10, 0};
    tbl[1] = '{0, 4,  25, 0};
    tbl[2] = '{0, 2,  50, 0};
    tbl[3] = '{0, 20, 5,  0};
    tbl[4] = '{0, 25, 4,  0};
    tbl[5] = '{0, 0,  0,  0};
    tbl[6] = '{1, 4,  7,  1};
    tbl[7] = '{1, 20, 2,  0};

    // Reset state.
    #1;
    chk("rst_freq",  bus_a.o_freq,  0);
    chk("rst_valid", bus_a.o_valid, 0);
    chk("rst_ovf",   bus_a.o_ovf,   0);
    chk("rst_drop",  bus_a.o_drop,  0);
    chk("rst_state", dbg_a, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    en = 1'b1;

    // Steady-rate vectors: two settling gates, then one clean gate checked.
    for (int i = 0; i < 8; i++) begin
      period = tbl[i].period;
      wait_valid(tbl[i].sel, cy);
      wait_valid(tbl[i].sel, cy);
      wait_valid(tbl[i].sel, cy);
      if (tbl[i].sel) begin
        chk($sformatf("tbl%0d_freq", i), bus_b.o_freq, tbl[i].exp_freq);
        chk($sformatf("tbl%0d_ovf", i),  bus_b.o_ovf,  tbl[i].exp_ovf);
        chk($sformatf("tbl%0d_gap", i),  cy, GB);
      end else begin
        chk($sformatf("tbl%0d_freq", i), bus_a.o_freq, tbl[i].exp_freq);
        chk($sformatf("tbl%0d_ovf", i),  bus_a.o_ovf,  tbl[i].exp_ovf);
        chk($sformatf("tbl%0d_gap", i),  cy, GA);
      end
    end

    // Boundary: edge counted exactly on the gate-end cycle belongs to the closing gate.
    period = 0;
    sig_manual = 1'b0;
    repeat (3) wait_valid(0, cy);
    c0 = cyc;
    wait_until(c0 + 100 - LAT);
    sig_manual = 1'b1;
    wait_until(c0 + 101 - LAT);
    sig_manual = 1'b0;
    wait_until(c0 + 100);
    chk("bnd_valid", bus_a.o_valid, 1);
    chk("bnd_freq",  bus_a.o_freq,  1);
    wait_valid(0, cy);
    chk("bnd_next_freq", bus_a.o_freq, 0);

    // Drop: hold across two gate ends with 10 then 7 edges.
    repeat (2) wait_valid(0, cy);
    c0 = cyc;
    v0 = va_cnt;
    d0 = da_cnt;
    hold_a = 1'b1;
    for (int j = 0; j < 10; j++) begin
      wait_until(c0 + 5 + 8 * j);
      sig_manual = 1'b1;
      wait_until(c0 + 6 + 8 * j);
      sig_manual = 1'b0;
    end
    for (int j = 0; j < 7; j++) begin
      wait_until(c0 + 110 + 10 * j);
      sig_manual = 1'b1;
      wait_until(c0 + 111 + 10 * j);
      sig_manual = 1'b0;
    end
    wait_until(c0 + 249);
    chk("drop_frozen_freq", bus_a.o_freq, 0);
    chk("drop_no_valid",    va_cnt - v0, 0);
    chk("drop_pulses",      da_cnt - d0, 1);
    wait_until(c0 + 250);
    hold_a = 1'b0;
    wait_until(c0 + 251);
    chk("drop_rel_valid", bus_a.o_valid, 1);
    chk("drop_rel_freq",  bus_a.o_freq,  7);

    // Hold across a single gate end.
    period = 10;
    repeat (3) wait_valid(0, cy);
    c0 = cyc;
    v0 = va_cnt;
    hold_a = 1'b1;
    wait_until(c0 + 150);
    chk("hold_no_valid", va_cnt - v0, 0);
    chk("hold_freq",     bus_a.o_freq, 10);
    hold_a = 1'b0;
    wait_until(c0 + 151);
    chk("hold_rel_valid", bus_a.o_valid, 1);
    chk("hold_rel_freq",  bus_a.o_freq,  10);
    wait_until(c0 + 152);
    chk("hold_valid_1cyc", bus_a.o_valid, 0);

    // Enable dropped mid-gate: partial gate discarded, restart after one IDLE cycle.
    wait_valid(0, cy);
    c0 = cyc;
    v0 = va_cnt;
    wait_until(c0 + 50);
    en = 1'b0;
    wait_until(c0 + 80);
    chk("en_no_valid", va_cnt - v0, 0);
    chk("en_state",    dbg_a, IDLE);
    en = 1'b1;
    wait_valid(0, cy);
    chk("en_restart_gap",  cy, GA + 1);
    chk("en_restart_freq", bus_a.o_freq, 10);

    // Asynchronous reset mid-gate.
    wait_until(cyc + 50);
    rst_n = 1'b0;
    #1;
    chk("arst_freq",    bus_a.o_freq,  0);
    chk("arst_valid",   bus_a.o_valid, 0);
    chk("arst_ovf",     bus_a.o_ovf,   0);
    chk("arst_drop",    bus_a.o_drop,  0);
    chk("arst_state",   dbg_a, IDLE);
    chk("arst_b_freq",  bus_b.o_freq,  0);
    chk("arst_b_state", dbg_b, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(0, cy);
    chk("arst_first_freq", bus_a.o_freq, 10);

    // Randomized run against the model.
    for (int s = 0; s < 30; s++) begin
      period = $urandom_range(2, 30);
      hold_a = ($urandom_range(0, 9) < 3);
      en     = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(20, 160)) @(negedge clk);
    end
    hold_a = 1'b0;
    en = 1'b1;
    repeat (300) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
